map_query_server: RTL

MAP_QUERY_SERVER -- requirements
Module: map_query_server

---
 rtl/pacman_map_pkg.sv | 30 +++
 rtl/map_tile_rom.sv | 27 ++
 rtl/map_query_server.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/pacman_map_pkg.sv
// Shared maze geometry, tile address type, direction encoding and server states.
package pacman_map_pkg;

  localparam int unsigned MAP_COLS   = 40;
  localparam int unsigned MAP_ROWS   = 30;
  localparam int unsigned TILE_SHIFT = 4;
  localparam int unsigned MAP_TILES  = MAP_COLS * MAP_ROWS;
  localparam int unsigned TUNNEL_ROW = 14;
  // Columns at or above this come from x-1 underflowing at the left edge
  localparam int unsigned TUNNEL_WRAP_HI = MAP_COLS + 12;

  typedef logic [10:0] tile_addr_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_t;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } srv_state_t;

  function automatic tile_addr_t tile_addr(input logic [4:0] row, input logic [5:0] col);
    return tile_addr_t'(row) * tile_addr_t'(MAP_COLS) + tile_addr_t'(col);
  endfunction

endpackage

// File: rtl/map_tile_rom.sv
// Maze wall and initial-pellet bits: bordered field with single-tile pillars and
// open tunnel ends on the tunnel row, which carries no pellets.
module map_tile_rom
  import pacman_map_pkg::*;
(
  input  tile_addr_t addr,
  output logic       wall,
  output logic       pellet
);

  int unsigned row;
  int unsigned col;

  always_comb begin
    row    = 32'(addr) / MAP_COLS;
    col    = 32'(addr) % MAP_COLS;
    wall   = 1'b1;
    pellet = 1'b0;
    if (32'(addr) < MAP_TILES) begin
      wall = (row == 0) || (row == MAP_ROWS - 1)
          || (((col == 0) || (col == MAP_COLS - 1)) && (row != TUNNEL_ROW))
          || (((row % 4) == 2) && ((col % 4) == 2));
      pellet = (row != TUNNEL_ROW);
    end
  end

endmodule

// File: rtl/map_query_server.sv
// Round-robin tile query server with a 2-cycle wall/pellet lookup pipeline.
// Optional feature: define MAP_TUNNEL_EN to wrap out-of-range columns.
module map_query_server #(
  parameter int NUM_REQ    = 4,
  parameter int TILE_SHIFT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*10-1:0] req_x,
  input  logic [NUM_REQ*9-1:0]  req_y,
  input  logic [NUM_REQ-1:0]    req_eat,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic                  rsp_wall,
  output logic                  rsp_pellet,
  output logic [10:0]           pellets_left,
  output logic                  all_eaten
);
  import pacman_map_pkg::*;

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam tile_addr_t LAST_ADDR = tile_addr_t'(MAP_TILES - 1);

  srv_state_t         state, state_nx;
  tile_addr_t         init_addr;
  logic [PW-1:0]      rr_ptr, gidx;
  logic [NUM_REQ-1:0] grant;
  int unsigned        cand;

  logic [9:0]         sel_x, col_raw;
  logic [8:0]         sel_y, row_raw;
  logic               sel_eat;
  logic [5:0]         col;
  logic               q_oob;
  tile_addr_t         q_addr;

  logic [NUM_REQ-1:0] s1_valid;
  tile_addr_t         s1_addr;
  logic               s1_oob, s1_eat;

  tile_addr_t         rom_addr;
  logic               rom_wall, rom_pellet;
  logic               bitmap [MAP_TILES];
  logic               bm_rd, s1_live, take;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_INIT;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_INIT: if (init_addr == LAST_ADDR) state_nx = ST_RUN;
      ST_RUN:  state_nx = ST_RUN;
      default: state_nx = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                                           init_addr <= '0;
    else if (state == ST_INIT && init_addr != LAST_ADDR) init_addr <= init_addr + 11'd1;
  end

  // Search starts at rr_ptr, which holds the index after the last grantee
  always_comb begin
    grant = '0;
    gidx  = '0;
    cand  = 0;
    if (state == ST_RUN) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        cand = (32'(rr_ptr) + i) % NUM_REQ;
        if (grant == '0 && req_valid[cand]) begin
          grant[cand] = 1'b1;
          gidx        = PW'(cand);
        end
      end
    end
  end

  assign req_ready = grant;

  always_ff @(posedge clk) begin
    if (rst)        rr_ptr <= '0;
    else if (|grant) rr_ptr <= (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
  end

  assign sel_x   = req_x[32'(gidx)*10 +: 10];
  assign sel_y   = req_y[32'(gidx)*9 +: 9];
  assign sel_eat = req_eat[gidx];
  assign col_raw = sel_x >> TILE_SHIFT;
  assign row_raw = sel_y >> TILE_SHIFT;

  always_comb begin
    col    = '0;
    q_oob  = 1'b0;
    q_addr = '0;
`ifdef MAP_TUNNEL_EN
    if (col_raw >= 10'(TUNNEL_WRAP_HI))  col = 6'(MAP_COLS - 1);
    else if (col_raw >= 10'(MAP_COLS))   col = '0;
    else                                 col = col_raw[5:0];
`else
    if (col_raw >= 10'(MAP_COLS)) q_oob = 1'b1;
    else                          col   = col_raw[5:0];
`endif
    if (row_raw >= 9'(MAP_ROWS)) q_oob = 1'b1;
    if (!q_oob) q_addr = tile_addr(row_raw[4:0], col);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= '0;
      s1_addr  <= '0;
      s1_oob   <= 1'b0;
      s1_eat   <= 1'b0;
    end else begin
      s1_valid <= grant;
      s1_addr  <= q_addr;
      s1_oob   <= q_oob;
      s1_eat   <= sel_eat;
    end
  end

  // The ROM port serves the sweep in INIT and the stage-1 lookup in RUN
  assign rom_addr = (state == ST_INIT) ? init_addr : s1_addr;

  map_tile_rom u_rom (
    .addr   (rom_addr),
    .wall   (rom_wall),
    .pellet (rom_pellet)
  );

  // Read and clear happen in the same stage, so a back-to-back eat sees the cleared bit
  assign bm_rd   = bitmap[s1_addr];
  assign s1_live = (|s1_valid) && !s1_oob;
  assign take    = s1_live && s1_eat && bm_rd;

  always_ff @(posedge clk) begin
    if (state == ST_INIT)  bitmap[init_addr] <= rom_pellet & ~rom_wall;
    else if (!rst && take) bitmap[s1_addr]   <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid    <= '0;
      rsp_wall     <= 1'b0;
      rsp_pellet   <= 1'b0;
      pellets_left <= '0;
    end else begin
      rsp_valid  <= s1_valid;
      rsp_wall   <= (|s1_valid) && (s1_oob || rom_wall);
      rsp_pellet <= s1_live && bm_rd;
      if (state == ST_INIT) begin
        if (rom_pellet && !rom_wall) pellets_left <= pellets_left + 11'd1;
      end else if (take && pellets_left != '0) begin
        pellets_left <= pellets_left - 11'd1;
      end
    end
  end

  assign all_eaten = (state == ST_RUN) && (pellets_left == '0);

endmodule
